sdp_memory: RTL
===============

# sdp_memory

Parametrised simple-dual-port memory for the systolic array datapath: one write port and one read port operate in the same cycle, with configurable read latency and configurable read-during-write behaviour. It replaces the fixed 16x256 single-port store wherever a PE row or weight/activation buffer must be filled and drained concurrently. A built-in clear sequencer zeroes the whole array after reset or on request, so the RAM needs no per-word reset.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 8, address width; depth is 2**ADDR_W words
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2
- WRITE_FIRST, 1, same-address read-during-write: 1 returns new data, 0 returns old data
- CLEAR_ON_RESET, 1, 1 means enter the clear sweep on reset release; 0 means go straight to IDLE

- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  request qualifier; when low, WR_EN and RD_EN are treated as 0
- CLEAR  in  1  single-cycle pulse that starts a zeroing sweep (sampled only in IDLE)
- READY  out  1  high in IDLE; requests are accepted only when READY is high
- WR_EN  in  1  write request
- WR_ADDR  in  ADDR_W  write address
- WR_DATA  in  DATA_W  write data
- RD_EN  in  1  read request
- RD_ADDR  in  ADDR_W  read address
- RD_DATA  out  DATA_W  read data; holds its last value when RD_VALID is low
- RD_VALID  out  1  one-cycle strobe per accepted read

## Operation
- States: CLEAR and IDLE.
- While RST is low:
  - state is CLEAR if CLEAR_ON_RESET = 1, otherwise IDLE
  - clear pointer = 0, READY = 0, RD_DATA = 0, RD_VALID = 0, read pipeline flushed
  - array contents are not reset
- CLEAR state:
  - one zero-write per cycle at the clear pointer, which increments by 1
  - after the edge that writes address 2**ADDR_W-1, state becomes IDLE
  - READY = 0 throughout; WR_EN, RD_EN and CLEAR are ignored
  - EN does not pause the sweep
- IDLE state: READY = 1.
  - Write accepted when EN & WR_EN: the array is updated at that edge.
  - Read accepted when EN & RD_EN: the result is delivered per Timing.
  - CLEAR = 1: state becomes CLEAR at that edge and the clear pointer resets to 0. A write or read presented in the same cycle is still accepted. An accepted write is overwritten by the sweep; an accepted read returns pre-sweep data.
- Read-during-write to the same address in the same cycle: WRITE_FIRST selects WR_DATA (1) or the old word (0). Different addresses are independent.
- Reads already in the pipeline complete normally if the block enters CLEAR. An asynchronous reset flushes them with no RD_VALID.
- Addresses wrap naturally at ADDR_W bits; there is no out-of-range case.

## Timing
- Full sweep: exactly 2**ADDR_W cycles. With CLEAR_ON_RESET = 1 and ADDR_W = 8, READY rises on the 256th rising edge after RST goes high.
- Read accepted at edge k:
  - READ_LAT = 1: RD_DATA and RD_VALID update at edge k+1 (registered RAM output)
  - READ_LAT = 2: they update at edge k+2 (extra output register)
- Reads are fully pipelined at one per cycle with no bubbles. RD_VALID stays high for N consecutive cycles for N back-to-back reads.
- Write at edge k is readable by a read accepted at edge k+1 or later. A read accepted at edge k itself follows the WRITE_FIRST rule.
- READY is a registered output: it falls at the edge that enters CLEAR and rises at the edge that leaves it.

## Test plan
- Reset release, CLEAR_ON_RESET = 1, ADDR_W = 8: READY low for 256 cycles, then high. Reading addresses 0, 17 and 255 returns 0x0000 with RD_VALID high exactly READ_LAT cycles after each request.
- Write 0xBEEF to address 0x10, then read 0x10 on the next cycle: RD_DATA = 0xBEEF with a one-cycle RD_VALID, for both READ_LAT = 1 and READ_LAT = 2.
- Same-cycle write of 0x1234 and read of address 0x20, which holds 0x5555: RD_DATA = 0x1234 when WRITE_FIRST = 1 and 0x5555 when WRITE_FIRST = 0. A concurrent write to 0x21 with a read of 0x20 returns 0x5555 in both builds.
- Eight back-to-back reads of addresses 0 to 7, pre-loaded with 0 to 7: RD_VALID high for 8 consecutive cycles, RD_DATA = 0, 1, …, 7 in order. Repeat with EN low during read 4: exactly 7 strobes, and value 3 is skipped.
- After loading data, pulse CLEAR with a simultaneous read of 0x10 (holding 0xBEEF): the read returns 0xBEEF. READY stays low for 256 cycles, requests issued during the sweep produce no RD_VALID and no writes, and 0x10 reads 0x0000 afterwards.
- Assert RST low mid-sweep and with reads in flight: RD_VALID, RD_DATA and READY go to 0 immediately (asynchronously), and the sweep restarts from address 0 on release.

Source files
------------

// File: rtl/sdp_memory.sv
// Simple-dual-port memory: one write port and one read port per cycle.
// Read latency is 1 or 2 cycles, and same-address read-during-write
// behaviour is selectable. A clear sequencer zeroes the whole array,
// one word per cycle, after reset or when CLEAR is pulsed in IDLE.
// Because of this sweep the array itself needs no reset.
module sdp_memory #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int READ_LAT       = 1,
    parameter int WRITE_FIRST    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              CLEAR,
    output logic              READY,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              RD_EN,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // Storage: no reset, the clear sweep provides known contents.
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              ready_q, ready_d;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_word_s;

    logic              rd_vld1_q, rd_vld1_d;
    logic [DATA_W-1:0] rd_dat1_q, rd_dat1_d;

    // Requests are qualified by EN and only accepted while READY is high.
    always_comb begin
        wr_acc_s = ready_q & EN & WR_EN;
        rd_acc_s = ready_q & EN & RD_EN;
    end

    // Next-state logic and write-port arbitration between sweep and user.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = WR_ADDR;
        mem_wdata_s = WR_DATA;
        case (state_q)
            ST_CLEAR: begin
                // Sweep owns the write port; user requests are ignored.
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_q;
                mem_wdata_s = {DATA_W{1'b0}};
                clr_ptr_d   = clr_ptr_q + ADDR_ONE;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                // A write accepted alongside CLEAR still lands; the sweep
                // overwrites it later.
                mem_we_s = wr_acc_s;
                if (ready_q && CLEAR) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = RESET_STATE;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Read word selection, including same-address read-during-write bypass.
    always_comb begin
        if ((WRITE_FIRST != 0) && wr_acc_s && (WR_ADDR == RD_ADDR)) begin
            rd_word_s = WR_DATA;
        end else begin
            rd_word_s = mem_q[RD_ADDR];
        end
        rd_vld1_d = rd_acc_s;
        if (rd_acc_s) begin
            rd_dat1_d = rd_word_s;
        end else begin
            rd_dat1_d = rd_dat1_q;
        end
    end

    // Array write port.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control state and first read stage (registered RAM output).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= RESET_STATE;
            clr_ptr_q <= {ADDR_W{1'b0}};
            ready_q   <= 1'b0;
            rd_vld1_q <= 1'b0;
            rd_dat1_q <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
            rd_vld1_q <= rd_vld1_d;
            rd_dat1_q <= rd_dat1_d;
        end
    end

    assign READY = ready_q;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              rd_vld2_q, rd_vld2_d;
            logic [DATA_W-1:0] rd_dat2_q, rd_dat2_d;

            // Extra output stage; data only advances with a valid beat.
            always_comb begin
                rd_vld2_d = rd_vld1_q;
                if (rd_vld1_q) begin
                    rd_dat2_d = rd_dat1_q;
                end else begin
                    rd_dat2_d = rd_dat2_q;
                end
            end

            // Output register for the two-cycle latency build.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    rd_vld2_q <= 1'b0;
                    rd_dat2_q <= {DATA_W{1'b0}};
                end else begin
                    rd_vld2_q <= rd_vld2_d;
                    rd_dat2_q <= rd_dat2_d;
                end
            end

            assign RD_VALID = rd_vld2_q;
            assign RD_DATA  = rd_dat2_q;
        end else begin : g_lat1
            assign RD_VALID = rd_vld1_q;
            assign RD_DATA  = rd_dat1_q;
        end
    endgenerate

endmodule
